// File: rtl/trng_map_pkg.sv
// Shared widths, types and FSM encoding for the TRNG select-map loader.
package trng_map_pkg;

    localparam int SEL_W            = 3;
    localparam int ADDR_W           = 4;
    localparam int ENTRIES_PER_WORD = 8;
    localparam int PAIRS_PER_WORD   = ENTRIES_PER_WORD / 2;
    localparam int DATA_W           = ENTRIES_PER_WORD * SEL_W;
    localparam int PC_W             = $clog2(PAIRS_PER_WORD);

    typedef logic [SEL_W-1:0]  map_sel_t;
    typedef logic [ADDR_W-1:0] map_addr_t;
    typedef logic [PC_W-1:0]   map_pc_t;
    typedef logic [PC_W:0]     map_ent_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } map_ld_state_e;

    // Extract select entry k from a packed config word.
    function automatic map_sel_t entry_of(input logic [DATA_W-1:0] data, input map_ent_t k);
        return data[int'(k)*SEL_W +: SEL_W];
    endfunction

endpackage

// File: rtl/trng_map_pair_pick.sv
// Finds the next pair with at least one enabled entry in a word mask.
// Used by trng_map_loader only when TRNG_MAP_LOADER_MASK_EN is defined.
module trng_map_pair_pick
    import trng_map_pkg::*;
(
    input  logic [ENTRIES_PER_WORD-1:0] mask,
    input  map_pc_t                     pc,
    input  logic                        from_start,
    output logic                        found,
    output map_pc_t                     next_pc,
    output logic                        next_is_last
);

    logic [PAIRS_PER_WORD-1:0] pair_en;
    logic [PAIRS_PER_WORD-1:0] cand;

    // from_start searches from pair 0 inclusive, otherwise strictly after pc.
    genvar gi;
    generate
        for (gi = 0; gi < PAIRS_PER_WORD; gi++) begin : g_pair
            assign pair_en[gi] = |mask[2*gi +: 2];
            assign cand[gi]    = pair_en[gi] && (from_start || (map_pc_t'(gi) > pc));
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        next_pc = '0;
        for (int p = PAIRS_PER_WORD - 1; p >= 0; p--) begin
            if (cand[p]) begin
                found   = 1'b1;
                next_pc = map_pc_t'(p);
            end
        end
        next_is_last = 1'b1;
        for (int p = 0; p < PAIRS_PER_WORD; p++) begin
            if (pair_en[p] && (map_pc_t'(p) > next_pc)) begin
                next_is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/trng_map_loader.sv
// Unpacks config words into paired writes to the TRNG select-map core.
// Optional per-entry write mask: define TRNG_MAP_LOADER_MASK_EN.
module trng_map_loader
    import trng_map_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic                        cfg_bank,
    input  logic [DATA_W-1:0]           cfg_data,
`ifdef TRNG_MAP_LOADER_MASK_EN
    input  logic [ENTRIES_PER_WORD-1:0] cfg_mask,
`endif
    output logic                        valid,
    output map_sel_t                    trng_sel1,
    output map_sel_t                    trng_sel2,
    output map_addr_t                   trng_sel1adress,
    output map_addr_t                   trng_sel2adress,
    output logic                        load_done
);

    map_ld_state_e     state_reg, state_next;
    map_pc_t           pc_reg, pc_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              bank_reg, bank_next;
    logic              valid_reg, valid_next;
    map_sel_t          sel1_reg, sel1_next;
    map_sel_t          sel2_reg, sel2_next;
    map_addr_t         addr1_reg, addr1_next;
    map_addr_t         addr2_reg, addr2_next;
    logic              load_done_reg, load_done_next;

    logic                        accept;
    logic                        load;
    logic                        cur_last;
    logic                        first_found;
    map_pc_t                     first_pc;
    logic                        first_last;
    map_pc_t                     step_pc;
    logic                        step_last;
    logic [ENTRIES_PER_WORD-1:0] word_mask;
    logic [ENTRIES_PER_WORD-1:0] held_mask;

    logic [DATA_W-1:0]           ld_data;
    logic                        ld_bank;
    logic [ENTRIES_PER_WORD-1:0] ld_mask;
    map_pc_t                     ld_pc;
    map_ent_t                    lo_idx, hi_idx;
    map_ent_t                    sel1_idx, sel2_idx;

`ifdef TRNG_MAP_LOADER_MASK_EN
    logic [ENTRIES_PER_WORD-1:0] mask_reg;
    logic                        step_found;

    assign word_mask = cfg_mask;
    assign held_mask = mask_reg;
    assign cur_last  = !step_found;

    trng_map_pair_pick u_first_pick (
        .mask        (cfg_mask),
        .pc          ('0),
        .from_start  (1'b1),
        .found       (first_found),
        .next_pc     (first_pc),
        .next_is_last(first_last)
    );

    trng_map_pair_pick u_step_pick (
        .mask        (mask_reg),
        .pc          (pc_reg),
        .from_start  (1'b0),
        .found       (step_found),
        .next_pc     (step_pc),
        .next_is_last(step_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '0;
        end else if (accept) begin
            mask_reg <= cfg_mask;
        end
    end
`else
    assign word_mask   = '1;
    assign held_mask   = '1;
    assign first_found = 1'b1;
    assign first_pc    = '0;
    assign first_last  = (PAIRS_PER_WORD == 1);
    assign step_pc     = pc_reg + 1'b1;
    assign step_last   = (step_pc == map_pc_t'(PAIRS_PER_WORD - 1));
    assign cur_last    = (pc_reg == map_pc_t'(PAIRS_PER_WORD - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            data_reg      <= '0;
            bank_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            sel1_reg      <= '0;
            sel2_reg      <= '0;
            addr1_reg     <= '0;
            addr2_reg     <= '0;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            data_reg      <= data_next;
            bank_reg      <= bank_next;
            valid_reg     <= valid_next;
            sel1_reg      <= sel1_next;
            sel2_reg      <= sel2_next;
            addr1_reg     <= addr1_next;
            addr2_reg     <= addr2_next;
            load_done_reg <= load_done_next;
        end
    end

    // A word whose mask enables nothing never leaves IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && first_found) state_next = ST_EMIT;
            ST_EMIT: if (cur_last) state_next = (accept && first_found) ? ST_EMIT : ST_IDLE;
        endcase
    end

    assign cfg_ready = (state_reg == ST_IDLE) || cur_last;
    assign accept    = cfg_valid && cfg_ready;

    // The pair being loaded comes from the new word on acceptance, else from the held word.
    assign ld_data  = accept ? cfg_data  : data_reg;
    assign ld_bank  = accept ? cfg_bank  : bank_reg;
    assign ld_mask  = accept ? word_mask : held_mask;
    assign ld_pc    = accept ? first_pc  : step_pc;
    assign lo_idx   = {ld_pc, 1'b0};
    assign hi_idx   = {ld_pc, 1'b1};
    assign sel1_idx = ld_mask[lo_idx] ? lo_idx : hi_idx;
    assign sel2_idx = ld_mask[hi_idx] ? hi_idx : lo_idx;

    always_comb begin
        pc_next        = pc_reg;
        data_next      = data_reg;
        bank_next      = bank_reg;
        sel1_next      = sel1_reg;
        sel2_next      = sel2_reg;
        addr1_next     = addr1_reg;
        addr2_next     = addr2_reg;
        load_done_next = 1'b0;
        load           = 1'b0;
        if (accept) begin
            data_next      = cfg_data;
            bank_next      = cfg_bank;
            pc_next        = first_pc;
            load           = first_found;
            load_done_next = first_found ? first_last : 1'b1;
        end else if (state_reg == ST_EMIT && !cur_last) begin
            pc_next        = step_pc;
            load           = 1'b1;
            load_done_next = step_last;
        end
        valid_next = load;
        if (load) begin
            sel1_next  = entry_of(ld_data, sel1_idx);
            sel2_next  = entry_of(ld_data, sel2_idx);
            addr1_next = {ld_bank, sel1_idx};
            addr2_next = {ld_bank, sel2_idx};
        end
    end

    assign valid           = valid_reg;
    assign trng_sel1       = sel1_reg;
    assign trng_sel2       = sel2_reg;
    assign trng_sel1adress = addr1_reg;
    assign trng_sel2adress = addr2_reg;
    assign load_done       = load_done_reg;

endmodule

// File: tb/tb_trng_map_loader.sv
// Self-checking bench for trng_map_loader: vector table, corner sequences and
// randomized words against a per-word expected-write model with exact cycle timing.
`timescale 1ns/1ps
module tb_trng_map_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_bank = 1'b0;
    logic [23:0] cfg_data = '0;
    logic [7:0]  cfg_mask_drv = 8'hFF;
    logic        cfg_ready;
    logic        valid;
    logic [2:0]  trng_sel1, trng_sel2;
    logic [3:0]  trng_sel1adress, trng_sel2adress;
    logic        load_done;

    always #5 clk = ~clk;

    trng_map_loader dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_bank       (cfg_bank),
        .cfg_data       (cfg_data),
`ifdef TRNG_MAP_LOADER_MASK_EN
        .cfg_mask       (cfg_mask_drv),
`endif
        .valid          (valid),
        .trng_sel1      (trng_sel1),
        .trng_sel2      (trng_sel2),
        .trng_sel1adress(trng_sel1adress),
        .trng_sel2adress(trng_sel2adress),
        .load_done      (load_done)
    );

    typedef struct {
        int         cyc;
        bit         wr;
        bit         last;
        logic [2:0] s1, s2;
        logic [3:0] a1, a2;
    } ev_t;

    typedef struct {
        logic [23:0] data;
        logic        bank;
        logic [7:0]  mask;
        int          ncyc;
        logic [2:0]  s1, s2;
        logic [3:0]  a1, a2;
    } vec_t;

    ev_t        exp_q[$];
    vec_t       tbl[$];
    int         cyc_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_writes = 0;
    logic [2:0] map_obs [16];
    logic [2:0] last_s1 = '0, last_s2 = '0;
    logic [3:0] last_a1 = '0, last_a2 = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] eff_mask(input logic [7:0] m);
`ifdef TRNG_MAP_LOADER_MASK_EN
        return m;
`else
        return 8'hFF;
`endif
    endfunction

    // Expected writes of one accepted word: each pair with enabled entries takes one cycle;
    // two enabled entries go to lanes 1/2, a single one is duplicated on both lanes.
    function automatic void push_word(input logic [23:0] d, input logic b, input logic [7:0] m, input int now);
        ev_t ev;
        int  t = now + 1;
        int  base = exp_q.size();
        int  ents[$];
        for (int p = 0; p < 4; p++) begin
            ents.delete();
            for (int k = 2 * p; k <= 2 * p + 1; k++) if (m[k]) ents.push_back(k);
            if (ents.size() == 0) continue;
            ev.cyc  = t;
            ev.wr   = 1'b1;
            ev.last = 1'b0;
            ev.s1   = 3'(d >> (3 * ents[0]));
            ev.s2   = 3'(d >> (3 * ents[ents.size() - 1]));
            ev.a1   = 4'(int'(b) * 8 + ents[0]);
            ev.a2   = 4'(int'(b) * 8 + ents[ents.size() - 1]);
            exp_q.push_back(ev);
            t++;
        end
        if (exp_q.size() == base) begin
            ev.cyc = t; ev.wr = 1'b0; ev.last = 1'b1;
            ev.s1 = '0; ev.s2 = '0; ev.a1 = '0; ev.a2 = '0;
            exp_q.push_back(ev);
        end else begin
            exp_q[exp_q.size() - 1].last = 1'b1;
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Monitor and reference model, sampled on the falling edge.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n_writes++;
                map_obs[trng_sel1adress] = trng_sel1;
                map_obs[trng_sel2adress] = trng_sel2;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
                ev = exp_q.pop_front();
                check("valid", 32'(valid), 32'(ev.wr));
                check("load_done", 32'(load_done), 32'(ev.last));
                if (ev.wr) begin
                    check("sel1", 32'(trng_sel1), 32'(ev.s1));
                    check("sel2", 32'(trng_sel2), 32'(ev.s2));
                    check("sel1adress", 32'(trng_sel1adress), 32'(ev.a1));
                    check("sel2adress", 32'(trng_sel2adress), 32'(ev.a2));
                    last_s1 = ev.s1; last_s2 = ev.s2; last_a1 = ev.a1; last_a2 = ev.a2;
                end
            end else begin
                check("idle_valid", 32'(valid), 32'd0);
                check("idle_load_done", 32'(load_done), 32'd0);
                check("hold_sel1", 32'(trng_sel1), 32'(last_s1));
                check("hold_sel2", 32'(trng_sel2), 32'(last_s2));
                check("hold_sel1adress", 32'(trng_sel1adress), 32'(last_a1));
                check("hold_sel2adress", 32'(trng_sel2adress), 32'(last_a2));
            end
            check("cfg_ready", 32'(cfg_ready), 32'(exp_q.size() == 0));
            if (rst) begin
                exp_q.delete();
                last_s1 = '0; last_s2 = '0; last_a1 = '0; last_a2 = '0;
            end else if (cfg_valid && cfg_ready) begin
                $display("[TB] word accepted cyc=%0d bank=%0d data=%06h mask=%02h",
                         cyc_cnt, cfg_bank, cfg_data, eff_mask(cfg_mask_drv));
                push_word(cfg_data, cfg_bank, eff_mask(cfg_mask_drv), cyc_cnt);
            end
        end
    end

    // Offer a word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_word(input logic [23:0] d, input logic b, input logic [7:0] m);
        int guard = 0;
        cfg_valid    = 1'b1;
        cfg_data     = d;
        cfg_bank     = b;
        cfg_mask_drv = m;
        @(negedge clk);
        while (!cfg_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!cfg_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got cfg_ready=0 for %0d cycles, expected 1", guard);
            cfg_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        cfg_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void add_vec(input logic [23:0] d, input logic b, input logic [7:0] m, input int n,
                                    input logic [2:0] s1, input logic [2:0] s2,
                                    input logic [3:0] a1, input logic [3:0] a2);
        vec_t v;
        v.data = d; v.bank = b; v.mask = m; v.ncyc = n;
        v.s1 = s1; v.s2 = s2; v.a1 = a1; v.a2 = a2;
        tbl.push_back(v);
    endfunction

    initial begin
        int n;
        int guard;
        int wr0;
        logic [7:0] m;

        for (int i = 0; i < 16; i++) map_obs[i] = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_sel1", 32'(trng_sel1), 32'd0);
        check("rst_sel2", 32'(trng_sel2), 32'd0);
        check("rst_sel1adress", 32'(trng_sel1adress), 32'd0);
        check("rst_sel2adress", 32'(trng_sel2adress), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        @(posedge clk);
        #1;

        add_vec(24'o76543210, 1'b0, 8'hFF, 4, 3'd0, 3'd1, 4'd0, 4'd1);
        add_vec(24'o55555555, 1'b1, 8'hFF, 4, 3'd5, 3'd5, 4'd8, 4'd9);
        add_vec(24'o01234567, 1'b1, 8'hFF, 4, 3'd7, 3'd6, 4'd8, 4'd9);
`ifdef TRNG_MAP_LOADER_MASK_EN
        add_vec(24'o76543210, 1'b0, 8'b0100_0010, 2, 3'd1, 3'd1, 4'd1, 4'd1);
        add_vec(24'o76543210, 1'b1, 8'b1100_0000, 1, 3'd6, 3'd7, 4'd14, 4'd15);
`endif

        foreach (tbl[i]) begin
            send_word(tbl[i].data, tbl[i].bank, tbl[i].mask);
            cfg_valid = 1'b0;
            @(negedge clk);
            check("tbl_valid", 32'(valid), 32'd1);
            check("tbl_sel1", 32'(trng_sel1), 32'(tbl[i].s1));
            check("tbl_sel2", 32'(trng_sel2), 32'(tbl[i].s2));
            check("tbl_sel1adress", 32'(trng_sel1adress), 32'(tbl[i].a1));
            check("tbl_sel2adress", 32'(trng_sel2adress), 32'(tbl[i].a2));
            n = (valid === 1'b1) ? 1 : 0;
            guard = 0;
            while (load_done !== 1'b1 && guard < 10) begin
                @(negedge clk);
                guard++;
                if (valid === 1'b1) n++;
            end
            check("tbl_burst_len", 32'(n), 32'(tbl[i].ncyc));
            @(posedge clk);
            #1;
        end

        // Back-to-back words; the second is held while the first is still emitting.
        for (int i = 0; i < 16; i++) map_obs[i] = '0;
        send_word(24'o76543210, 1'b0, 8'hFF);
        send_word(24'o55555555, 1'b1, 8'hFF);
        idle_cycles(10);
        for (int i = 0; i < 8; i++) begin
            check("b2b_map_lo", 32'(map_obs[i]), 32'(i));
            check("b2b_map_hi", 32'(map_obs[8 + i]), 32'd5);
        end

        // Reset during the first emitted pair: only pair 0 reaches the map.
        wr0 = n_writes;
        send_word(24'o76543210, 1'b0, 8'hFF);
        cfg_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_ready", 32'(cfg_ready), 32'd1);
        check("rst_mid_writes", 32'(n_writes - wr0), 32'd1);
        @(posedge clk);
        #1;

`ifdef TRNG_MAP_LOADER_MASK_EN
        send_word(24'o76543210, 1'b0, 8'b0100_0010);
        cfg_valid = 1'b0;
        @(negedge clk);
        check("mask_p0_valid", 32'(valid), 32'd1);
        check("mask_p0_sel", 32'({trng_sel1, trng_sel2}), 32'({3'd1, 3'd1}));
        check("mask_p0_addr", 32'({trng_sel1adress, trng_sel2adress}), 32'({4'd1, 4'd1}));
        check("mask_p0_done", 32'(load_done), 32'd0);
        @(negedge clk);
        check("mask_p1_sel", 32'({trng_sel1, trng_sel2}), 32'({3'd6, 3'd6}));
        check("mask_p1_addr", 32'({trng_sel1adress, trng_sel2adress}), 32'({4'd6, 4'd6}));
        check("mask_p1_done", 32'(load_done), 32'd1);
        @(negedge clk);
        check("mask_after_valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1;

        send_word(24'o12345670, 1'b1, 8'h00);
        cfg_valid = 1'b0;
        @(negedge clk);
        check("mask0_valid", 32'(valid), 32'd0);
        check("mask0_done", 32'(load_done), 32'd1);
        check("mask0_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        check("mask0_done_clear", 32'(load_done), 32'd0);
        @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 2);
            if (n > 0) idle_cycles(n);
            m = 8'($urandom);
            if ($urandom_range(0, 3) == 0) m = 8'hFF;
            send_word(24'($urandom), 1'($urandom), m);
        end
        idle_cycles(12);
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/trng_map_loader.md
# trng_map_loader

Sequencer directly upstream of the TRNG select-map core. Accepts packed select-map words from the configuration side over a valid/ready handshake and unpacks each word into a burst of paired writes on the `valid`/`trng_sel1`/`trng_sel2`/`trng_sel1adress`/`trng_sel2adress` port group. Each `valid` cycle programs two map entries. The map core's write port is driven only by this block.

## Interface
- `ENTRIES_PER_WORD`, 8: select entries per config word; must be even.
- `SEL_W`, 3: select field width.
- `ADDR_W`, 4: map entry address width; 16 addressable entries.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_valid`  in  1  config word offered.
- `cfg_ready`  out  1  loader can accept a word this cycle.
- `cfg_bank`  in  1  0 = entries 0–7, 1 = entries 8–15.
- `cfg_data`  in  24  entry k at bits [3k+2:3k], k = 0..7.
- `cfg_mask`  in  8  per-entry write enable; present only with `TRNG_MAP_LOADER_MASK_EN`.
- `valid`  out  1  pair write strobe to map core.
- `trng_sel1`, `trng_sel2`  out  3  select values.
- `trng_sel1adress`, `trng_sel2adress`  out  4  entry addresses.
- `load_done`  out  1  one-cycle pulse on the last write of a word.

## Operation
- FSM states: IDLE, EMIT. A 2-bit pair counter `pc` is used in EMIT.
- IDLE: `cfg_ready`=1. On `cfg_valid & cfg_ready`, latch `cfg_data`, `cfg_bank` (and mask), set `pc`=0, go to EMIT.
- EMIT, per cycle:
  - `valid`=1.
  - `trng_sel1` = entry[2·pc], `trng_sel2` = entry[2·pc+1].
  - `trng_sel1adress` = {bank, 2·pc}, `trng_sel2adress` = {bank, 2·pc+1}. Arithmetic is 3-bit; the bank bit is the address MSB.
  - `pc` increments each cycle.
- Last pair (`pc`=3):
  - `load_done`=1 and `cfg_ready`=1.
  - If a word is accepted in this cycle, stay in EMIT with `pc`=0 on the new word. `valid` stays high with no gap.
  - Otherwise go to IDLE.
- `cfg_ready`=0 on all other EMIT cycles. The handshake obeys standard rules: the producer holds `cfg_*` stable until accepted.
- Two entries of one pair never share an address. Consecutive pairs never repeat an address, except as defined under Configuration.
- Reset mid-burst: the remaining pairs are discarded. The next cycle shows IDLE, `valid`=0, and a partially written map stays as written.

## Timing
- All outputs are registered.
- Reset values: `valid`=0, `trng_sel*`=0, `trng_sel*adress`=0, `load_done`=0, `cfg_ready`=1 (combinational from state; 1 during and after reset).
- Acceptance at edge N: `valid` is high in cycles N+1..N+4; `load_done` is high in N+4.
- Throughput: one word per 4 cycles, sustained back-to-back.
- The map core captures pairs in the same cycle `valid` is high, so no extra hold cycle is inserted.
- When `valid`=0, `trng_sel*` and `trng_sel*adress` hold their last values.

## Configuration
- `TRNG_MAP_LOADER_MASK_EN` defined:
  - The `cfg_mask` port exists and is latched with the word.
  - A pair with both mask bits 0 is skipped and consumes no cycle.
  - A pair with exactly one bit set drives the enabled entry on both sel1 and sel2: same address, same value.
  - `load_done` fires on the last emitted pair.
  - An all-zero mask emits no `valid`. `load_done` pulses at N+1 and the FSM returns to IDLE (`cfg_ready`=1 at N+1).
- Not defined: no port, all entries are written, fixed 4-cycle bursts.

## Structure
- Package `trng_map_pkg` holds:
  - `SEL_W`, `ADDR_W`, `ENTRIES_PER_WORD`, `PAIRS_PER_WORD`.
  - Typedef `map_sel_t` (logic [SEL_W-1:0]) and `map_addr_t`.
  - The FSM state enum `map_ld_state_e`.
- One sub-module, `trng_map_pair_pick`: combinational. Given latched mask and current `pc`, it returns the next enabled pair index and an `is_last` flag.
  - Instantiated only under `TRNG_MAP_LOADER_MASK_EN`.
  - Without the macro, `pc+1` and `pc==3` are used directly.

## Test plan
- Reset with `rst`=1 for 2 cycles, then release → `valid`=0, all sel/addr outputs 0, `cfg_ready`=1.
- Single word, `cfg_bank`=0, `cfg_data` = entries 0..7 holding values 0..7 (24'o76543210) → pairs (0,1)@0/1, (2,3)@2/3, (4,5)@4/5, (6,7)@6/7 over 4 cycles; `load_done` on the 4th.
- Two words back-to-back, second with `cfg_bank`=1 and all entries 3'd5 → 8 contiguous `valid` cycles; addresses 8..15 carry 5; `cfg_ready` high only in cycles 4 and 8.
- `rst` asserted at the 2nd EMIT cycle → next cycle `valid`=0 and `cfg_ready`=1; only pair 0 written.
- `cfg_valid` held with `cfg_ready`=0 mid-burst → word not accepted until the last pair; data stable; no lost or duplicated word.
- MASK_EN, `cfg_mask`=8'b0100_0010 → two `valid` cycles: entry 1 @ addr 1 on both lanes, then entry 6 @ addr 6 on both lanes; `load_done` on the second. Mask 0 → no `valid`, `load_done` at N+1.
